shift_sub_div: RTL and testbench

Sequential restoring divider, unsigned, MSB-first shift-subtract: one quotient bit per clock. It is the inverse of the shift-add multiply-accumulate unit and shares its operand width and iteration style. It runs beside the MAC in the arithmetic demo datapath, so a bench can close the loop: A = Q*B + R. The interface is a start/busy/done handshake.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 26 ++
 rtl/shift_sub_div.sv | 126 ++++++++++++
 tb/tb_shift_sub_div.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: FSM state encoding and default operand width.
package div_pkg;

  localparam int DIV_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic [N:0]   r_i,
  input  logic         bit_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   r_o,
  output logic         q_o
);

  logic [N:0] t;
  logic [N:0] b_ext;

  // r_i < b_i always holds, so r_i[N] is zero and dropping it in the shift is lossless.
  always_comb begin
    t     = (N+1)'({r_i, bit_i});
    b_ext = {1'b0, b_i};
    q_o   = (t >= b_ext);
    r_o   = q_o ? (t - b_ext) : t;
  end

endmodule

// File: rtl/shift_sub_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV_ZERO_EARLY_EN: a zero divisor finishes one cycle after start.
module shift_sub_div
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output div_state_e   dbg_state
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);

  div_state_e   state_q;
  logic [IW-1:0] i_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic [N:0]   r_q;
  logic [N-1:0] qw_q;
  logic [N-1:0] qw_d;
  logic [N-1:0] q_out_q;
  logic [N-1:0] r_out_q;
  logic         busy_q;
  logic         done_q;
  logic         dbz_q;

  logic [N:0]   step_r;
  logic         step_q;

  div_step #(.N(N)) u_step (
    .r_i   (r_q),
    .bit_i (a_q[i_q]),
    .b_i   (b_q),
    .r_o   (step_r),
    .q_o   (step_q)
  );

  always_comb begin
    qw_d      = qw_q;
    qw_d[i_q] = step_q;
  end

  // Handshake: start is taken only in IDLE or DONE; busy is high for the N
  // iteration cycles; done pulses for one cycle when Q/R/div_by_zero update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      qw_q    <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q  <= A;
            b_q  <= B;
            r_q  <= '0;
            i_q  <= I_LAST;
            qw_q <= '0;
`ifdef DIV_ZERO_EARLY_EN
            if (B == '0) begin
              state_q <= ST_DONE;
              q_out_q <= '1;
              r_out_q <= A;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
`else
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_q  <= step_r;
          qw_q <= qw_d;
          if (i_q == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            q_out_q <= qw_d;
            r_out_q <= step_r[N-1:0];
            dbz_q   <= (b_q == '0);
          end else begin
            i_q <= i_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q           = q_out_q;
  assign R           = r_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_shift_sub_div.sv
// Self-checking bench for shift_sub_div: directed and random divisions against an arithmetic reference.
module tb_shift_sub_div;
  import div_pkg::*;

  localparam int N = 4;
  localparam int MAXV = (1 << N) - 1;
`ifdef DIV_ZERO_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_NORM = N + 1;
  localparam int LAT_ZERO = EARLY ? 1 : N + 1;
  localparam int BUSY_ZERO = EARLY ? 0 : N;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [N-1:0] A, B, Q, R;
  logic busy, done, div_by_zero;
  div_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*N-1:0] exp_q[$];

  always #5 clk = ~clk;

  shift_sub_div #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = MAXV;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] q, output logic [N-1:0] r, output logic z,
                        output int lat, output int bcnt, output bit ok);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; ok = 1'b0; q = '0; r = '0; z = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) begin
        q = Q; r = R; z = div_by_zero; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    checks++; if (Q !== '0) begin errors++; $display("FAIL reset_q got %0d want 0", Q); end
    checks++; if (R !== '0) begin errors++; $display("FAIL reset_r got %0d want 0", R); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div_by_zero}); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [N-1:0] q, r; logic z; int lat, bcnt; bit ok;
    run_op(4'd13, 4'd3, q, r, z, lat, bcnt, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin errors++; $display("FAIL basic_13_3 got q=%0d r=%0d z=%0b want q=4 r=1 z=0", q, r, z); end
    checks++; if (lat != LAT_NORM) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT_NORM); end
    checks++; if (bcnt != N) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bcnt, N); end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || Q !== 4'd4 || R !== 4'd1) begin errors++; $display("FAIL basic_hold got done=%0b q=%0d r=%0d want done=0 q=4 r=1", done, Q, R); end
  endtask

  task automatic test_directed();
    int ta[3] = '{15, 7, 1};
    int tb[3] = '{1, 9, 15};
    logic [N-1:0] q, r; logic z; int lat, bcnt; bit ok; int eq, er;
    for (int k = 0; k < 3; k++) begin
      ref_div(ta[k], tb[k], eq, er);
      run_op(N'(ta[k]), N'(tb[k]), q, r, z, lat, bcnt, ok);
      checks++;
      if (!ok || int'(q) != eq || int'(r) != er || z !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_%0d got ok=%0b q=%0d r=%0d z=%0b want q=%0d r=%0d z=0", ta[k], tb[k], ok, q, r, z, eq, er);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] q, r; logic z; int lat, bcnt; bit ok; int a, b, eq, er;
    for (int k = 0; k < 32; k++) begin
      a = int'($urandom_range(0, MAXV));
      b = int'($urandom_range(1, MAXV));
      ref_div(a, b, eq, er);
      run_op(N'(a), N'(b), q, r, z, lat, bcnt, ok);
      checks++;
      if (!ok || int'(q) * b + int'(r) != a || int'(r) >= b || int'(q) != eq || z !== 1'b0 || lat != LAT_NORM) begin
        errors++;
        $display("FAIL random_%0d_%0d got ok=%0b q=%0d r=%0d z=%0b lat=%0d want q=%0d r=%0d z=0 lat=%0d", a, b, ok, q, r, z, lat, eq, er, LAT_NORM);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] q, r; logic z; int lat, bcnt; bit ok;
    run_op(4'd9, 4'd0, q, r, z, lat, bcnt, ok);
    checks++; if (!ok || q !== 4'd15 || r !== 4'd9 || z !== 1'b1) begin errors++; $display("FAIL divzero_result got ok=%0b q=%0d r=%0d z=%0b want q=15 r=9 z=1", ok, q, r, z); end
    checks++; if (lat != LAT_ZERO) begin errors++; $display("FAIL divzero_latency got %0d want %0d", lat, LAT_ZERO); end
    checks++; if (bcnt != BUSY_ZERO) begin errors++; $display("FAIL divzero_busy got %0d want %0d", bcnt, BUSY_ZERO); end
    run_op(4'd6, 4'd2, q, r, z, lat, bcnt, ok);
    checks++; if (!ok || q !== 4'd3 || r !== 4'd0 || z !== 1'b0) begin errors++; $display("FAIL divzero_clear got q=%0d r=%0d z=%0b want q=3 r=0 z=0", q, r, z); end
  endtask

  task automatic test_start_ignored();
    int lat; bit ok;
    @(negedge clk);
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; A = '0; B = '0;
    lat = 0; ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin A = 4'd2; B = 4'd1; start = 1'b1; end
      if (lat == 3) begin A = '0; B = '0; start = 1'b0; end
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || Q !== 4'd4 || R !== 4'd1 || lat != LAT_NORM) begin
      errors++;
      $display("FAIL start_ignored got ok=%0b q=%0d r=%0d lat=%0d want q=4 r=1 lat=%0d", ok, Q, R, lat, LAT_NORM);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, eq, er, gap, n_done;
    logic [2*N-1:0] e;
    @(negedge clk);
    a = int'($urandom_range(0, MAXV)); b = int'($urandom_range(1, MAXV));
    ref_div(a, b, eq, er);
    exp_q.push_back({N'(eq), N'(er)});
    A = N'(a); B = N'(b); start = 1'b1;
    gap = 0; n_done = 0;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if ({Q, R} !== e) begin errors++; $display("FAIL b2b_result_%0d got q=%0d r=%0d want q=%0d r=%0d", n_done, Q, R, e[2*N-1:N], e[N-1:0]); end
        checks++;
        if (gap != N + 1) begin errors++; $display("FAIL b2b_spacing_%0d got %0d want %0d", n_done, gap, N + 1); end
        gap = 0;
        n_done++;
        if (n_done < 4) begin
          a = int'($urandom_range(0, MAXV)); b = int'($urandom_range(1, MAXV));
          ref_div(a, b, eq, er);
          exp_q.push_back({N'(eq), N'(er)});
          A = N'(a); B = N'(b);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n_done); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] q, r; logic z; int lat, bcnt; bit ok; bit saw_done;
    run_op(4'd5, 4'd0, q, r, z, lat, bcnt, ok);
    @(negedge clk);
    A = 4'd13; B = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Q !== '0 || R !== '0 || {busy, done, div_by_zero} !== 3'b000 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL midrun_async_clear got q=%0d r=%0d flags=%b st=%0d want all 0", Q, R, {busy, done, div_by_zero}, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL midrun_abandoned got activity want none"); end
    run_op(4'd10, 4'd4, q, r, z, lat, bcnt, ok);
    checks++; if (!ok || q !== 4'd2 || r !== 4'd2 || z !== 1'b0) begin errors++; $display("FAIL midrun_next got ok=%0b q=%0d r=%0d z=%0b want q=2 r=2 z=0", ok, q, r, z); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
